// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the memory stage: funct3 codes, LSU states,
// and small decode helpers for store-lane placement and alignment.
package rv32i_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, DONE} lsu_state_e;

  typedef struct packed {
    logic [XLEN-1:0] wdata;
    logic [3:0]      wmask;
  } store_lanes_t;

  // Unsigned widths exist only for loads.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !is_store;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    return ((f3 == F3_H || f3 == F3_HU) && lo[0]) || (f3 == F3_W && lo != 2'b00);
  endfunction

  function automatic logic [1:0] align_lo(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_H, F3_HU: return {lo[1], 1'b0};
      F3_W:        return 2'b00;
      default:     return lo;
    endcase
  endfunction

  function automatic store_lanes_t store_lanes(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [XLEN-1:0] data);
    store_lanes_t s;
    case (f3)
      F3_B:    begin s.wdata = {4{data[7:0]}};  s.wmask = 4'b0001 << lo; end
      F3_H:    begin s.wdata = {2{data[15:0]}}; s.wmask = 4'b0011 << {lo[1], 1'b0}; end
      default: begin s.wdata = data;            s.wmask = 4'b1111; end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus: single outstanding req/ack transaction, word-addressed with byte enables.
interface load_store_unit_if;
  import rv32i_pkg::*;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_wmask;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/load_store_unit_load_extend.sv
// Combinational load lane select with sign/zero extension; shared by any
// path that returns a raw 32-bit memory word.
module load_extend
  import rv32i_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = rdata[{addr_lo, 3'b000} +: 8];
  assign half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    result = '0;
    case (funct3)
      F3_B:    result = {{24{byte_v[7]}}, byte_v};
      F3_H:    result = {{16{half_v[15]}}, half_v};
      F3_W:    result = rdata;
      F3_BU:   result = {24'h0, byte_v};
      F3_HU:   result = {16'h0, half_v};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory-access stage: one outstanding req/ack transaction with timeout.
// Optional MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of aligning them.
module load_store_unit
  import rv32i_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  input  logic            load,
  input  logic            store,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] rs2_data,
  output logic            stall,
  output logic            done,
  output logic            bus_err,
  output logic            misaligned,
  output logic [XLEN-1:0] byte_accessL,
  load_store_unit_if.master mem
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  lsu_state_e      state;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_nxt;
  logic [2:0]      f3_q;
  logic [1:0]      addr_lo_q;
  logic            is_load_q;

  logic            is_store;
  logic            accept;
  logic            f3_ok;
  logic            mis;
  logic [1:0]      eff_lo;
  store_lanes_t    lanes;
  logic [XLEN-1:0] ext_result;

  // A simultaneous load+store executes as a load.
  assign is_store = store & ~load;
  assign accept   = (state == IDLE) & op_valid & (load | store);
  assign f3_ok    = f3_legal(funct3, is_store);

`ifdef MISALIGN_TRAP_EN
  assign mis    = is_misaligned(funct3, alu_out[1:0]);
  assign eff_lo = alu_out[1:0];
`else
  assign mis    = 1'b0;
  assign eff_lo = align_lo(funct3, alu_out[1:0]);
  assign misaligned = 1'b0;
`endif

  assign lanes    = store_lanes(funct3, eff_lo, rs2_data);
  assign wait_nxt = wait_cnt + CNT_W'(1);
  assign stall    = accept | (state == REQ);

  load_extend u_load_extend (
    .rdata   (mem.mem_rdata),
    .addr_lo (addr_lo_q),
    .funct3  (f3_q),
    .result  (ext_result)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      f3_q          <= '0;
      addr_lo_q     <= '0;
      is_load_q     <= 1'b0;
      done          <= 1'b0;
      bus_err       <= 1'b0;
      byte_accessL  <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      mem.mem_wmask <= '0;
`ifdef MISALIGN_TRAP_EN
      misaligned    <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      bus_err <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misaligned <= 1'b0;
`endif
      case (state)
        IDLE: if (accept) begin
          f3_q      <= funct3;
          addr_lo_q <= eff_lo;
          is_load_q <= ~is_store;
          wait_cnt  <= '0;
          if (!f3_ok || mis) begin
            // Illegal or trapped accesses never touch the bus.
            state   <= DONE;
            done    <= 1'b1;
            bus_err <= ~f3_ok;
`ifdef MISALIGN_TRAP_EN
            misaligned <= f3_ok & mis;
`endif
          end else begin
            state         <= REQ;
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= is_store;
            mem.mem_addr  <= {alu_out[XLEN-1:2], 2'b00};
            mem.mem_wdata <= is_store ? lanes.wdata : '0;
            mem.mem_wmask <= is_store ? lanes.wmask : 4'b0000;
          end
        end
        REQ: begin
          if (mem.mem_ack) begin
            state         <= DONE;
            done          <= 1'b1;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_wmask <= 4'b0000;
            if (is_load_q) byte_accessL <= ext_result;
          end else begin
            wait_cnt <= wait_nxt;
            if (wait_nxt == CNT_W'(MAX_WAIT)) begin
              state         <= DONE;
              done          <= 1'b1;
              bus_err       <= 1'b1;
              mem.mem_req   <= 1'b0;
              mem.mem_we    <= 1'b0;
              mem.mem_wmask <= 4'b0000;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a default instance plus a MAX_WAIT=4
// instance for the timeout path. Outputs are sampled on the falling edge.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid, op_valid2;
  logic        load, store;
  logic [2:0]  funct3;
  logic [31:0] alu_out, rs2_data;

  logic        stall, done, bus_err, misaligned;
  logic [31:0] byte_accessL;
  logic        stall2, done2, bus_err2, misaligned2;
  logic [31:0] byte_accessL2;

  int checks   = 0;
  int failures = 0;

  load_store_unit_if bus ();
  load_store_unit_if bus2 ();

  load_store_unit dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .load(load), .store(store),
    .funct3(funct3), .alu_out(alu_out), .rs2_data(rs2_data),
    .stall(stall), .done(done), .bus_err(bus_err), .misaligned(misaligned),
    .byte_accessL(byte_accessL), .mem(bus.master)
  );

  load_store_unit #(.MAX_WAIT(4)) dut2 (
    .clk(clk), .rst(rst), .op_valid(op_valid2), .load(load), .store(store),
    .funct3(funct3), .alu_out(alu_out), .rs2_data(rs2_data),
    .stall(stall2), .done(done2), .bus_err(bus_err2), .misaligned(misaligned2),
    .byte_accessL(byte_accessL2), .mem(bus2.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present an op in the current cycle, confirm the accept-cycle stall, and
  // return at the falling edge of the first cycle after acceptance.
  task automatic start_op(input bit second, input logic ld, input logic st,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] data, input logic exp_stall);
    load = ld; store = st; funct3 = f3; alu_out = addr; rs2_data = data;
    if (second) op_valid2 = 1'b1; else op_valid = 1'b1;
    #1;
    check("accept_stall", second ? stall2 : stall, exp_stall);
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0; op_valid2 = 1'b0; load = 1'b0; store = 1'b0;
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_valid2 = 1'b0; load = 1'b0; store = 1'b0;
    funct3 = 3'b000; alu_out = '0; rs2_data = '0;
    bus.mem_ack = 1'b0;  bus.mem_rdata = '0;
    bus2.mem_ack = 1'b0; bus2.mem_rdata = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_stall", stall, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_bus_err", bus_err, 1'b0);
    check("rst_misaligned", misaligned, 1'b0);
    check("rst_result", byte_accessL, 32'h0);
    check("rst_req", bus.mem_req, 1'b0);
    check("rst_we", bus.mem_we, 1'b0);
    check("rst_addr", bus.mem_addr, 32'h0);
    check("rst_wdata", bus.mem_wdata, 32'h0);
    check("rst_wmask", bus.mem_wmask, 4'h0);
    rst = 1'b0;
    @(negedge clk);

    // LB 0x1003, ack in first REQ cycle
    start_op(1'b0, 1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 1'b1);
    check("lb_req", bus.mem_req, 1'b1);
    check("lb_we", bus.mem_we, 1'b0);
    check("lb_addr", bus.mem_addr, 32'h0000_1000);
    check("lb_wmask", bus.mem_wmask, 4'h0);
    check("lb_no_done_yet", done, 1'b0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h80FF_1234;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("lb_done", done, 1'b1);
    check("lb_bus_err", bus_err, 1'b0);
    check("lb_result", byte_accessL, 32'hFFFF_FF80);
    check("lb_stall_done", stall, 1'b0);
    check("lb_req_dropped", bus.mem_req, 1'b0);
    @(negedge clk);
    check("lb_done_pulse", done, 1'b0);

    // SH 0x2002
    start_op(1'b0, 1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'hABCD_5678, 1'b1);
    check("sh_addr", bus.mem_addr, 32'h0000_2000);
    check("sh_wdata", bus.mem_wdata, 32'h5678_5678);
    check("sh_wmask", bus.mem_wmask, 4'b1100);
    check("sh_we", bus.mem_we, 1'b1);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("sh_done", done, 1'b1);
    check("sh_result_kept", byte_accessL, 32'hFFFF_FF80);
    @(negedge clk);

    // LHU 0x0, ack after 5 waiting cycles
    start_op(1'b0, 1'b1, 1'b0, 3'b101, 32'h0, 32'h0, 1'b1);
    bus.mem_rdata = 32'hFFFF_1234;
    for (int i = 0; i < 5; i++) begin
      check("lhu_wait_stall", stall, 1'b1);
      check("lhu_wait_req", bus.mem_req, 1'b1);
      check("lhu_wait_addr", bus.mem_addr, 32'h0);
      check("lhu_wait_done", done, 1'b0);
      @(negedge clk);
    end
    check("lhu_last_req", bus.mem_req, 1'b1);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("lhu_done", done, 1'b1);
    check("lhu_result", byte_accessL, 32'h0000_1234);
    @(negedge clk);

    // Timeout on the MAX_WAIT=4 instance
    start_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_3000, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("to_req", bus2.mem_req, 1'b1);
      check("to_stall", stall2, 1'b1);
      @(negedge clk);
    end
    check("to_req_dropped", bus2.mem_req, 1'b0);
    check("to_done", done2, 1'b1);
    check("to_bus_err", bus_err2, 1'b1);
    check("to_result_kept", byte_accessL2, 32'h0);
    @(negedge clk);
    check("to_done_pulse", done2, 1'b0);

    // LW 0x1002
`ifdef MISALIGN_TRAP_EN
    start_op(1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_1002, 32'h0, 1'b1);
    check("lw_mis_req", bus.mem_req, 1'b0);
    check("lw_mis_done", done, 1'b1);
    check("lw_mis_flag", misaligned, 1'b1);
    check("lw_mis_bus_err", bus_err, 1'b0);
    check("lw_mis_result", byte_accessL, 32'h0000_1234);
`else
    start_op(1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_1002, 32'h0, 1'b1);
    check("lw_al_req", bus.mem_req, 1'b1);
    check("lw_al_addr", bus.mem_addr, 32'h0000_1000);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("lw_al_done", done, 1'b1);
    check("lw_al_mis", misaligned, 1'b0);
    check("lw_al_result", byte_accessL, 32'hDEAD_BEEF);
`endif
    @(negedge clk);

    // Illegal funct3: store-unsigned and 011 load
    start_op(1'b0, 1'b0, 1'b1, 3'b100, 32'h0000_0040, 32'h1, 1'b1);
    check("ill_st_req", bus.mem_req, 1'b0);
    check("ill_st_done", done, 1'b1);
    check("ill_st_err", bus_err, 1'b1);
    @(negedge clk);
    start_op(1'b0, 1'b1, 1'b0, 3'b011, 32'h0000_0040, 32'h0, 1'b1);
    check("ill_ld_req", bus.mem_req, 1'b0);
    check("ill_ld_err", bus_err, 1'b1);
    @(negedge clk);
    check("ill_err_pulse", bus_err, 1'b0);

    // load+store together runs as LB at lane 0
    start_op(1'b0, 1'b1, 1'b1, 3'b000, 32'h0000_0010, 32'hFFFF_FFFF, 1'b1);
    check("both_we", bus.mem_we, 1'b0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_00A5;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("both_result", byte_accessL, 32'hFFFF_FFA5);
    @(negedge clk);

    // LBU lane 2 with MSB set
    start_op(1'b0, 1'b1, 1'b0, 3'b100, 32'h0000_0002, 32'h0, 1'b1);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h00C3_0000;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("lbu_result", byte_accessL, 32'h0000_00C3);
    @(negedge clk);

    // LH upper half
    start_op(1'b0, 1'b1, 1'b0, 3'b001, 32'h0000_0002, 32'h0, 1'b1);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h8001_0000;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("lh_result", byte_accessL, 32'hFFFF_8001);
    @(negedge clk);

    // SB lane 1
    start_op(1'b0, 1'b0, 1'b1, 3'b000, 32'h0000_0005, 32'h1122_3344, 1'b1);
    check("sb_addr", bus.mem_addr, 32'h0000_0004);
    check("sb_wdata", bus.mem_wdata, 32'h4444_4444);
    check("sb_wmask", bus.mem_wmask, 4'b0010);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("sb_result_kept", byte_accessL, 32'hFFFF_8001);
    @(negedge clk);

    // op_valid without load/store is a no-op; stray ack ignored
    bus.mem_ack = 1'b1;
    start_op(1'b0, 1'b0, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 1'b0);
    bus.mem_ack = 1'b0;
    check("nop_req", bus.mem_req, 1'b0);
    check("nop_done", done, 1'b0);

    // Reset while in REQ, then a late ack
    start_op(1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 1'b1);
    check("rreq_req", bus.mem_req, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rreq_req_drop", bus.mem_req, 1'b0);
    check("rreq_stall", stall, 1'b0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rreq_late_done", done, 1'b0);
      check("rreq_late_req", bus.mem_req, 1'b0);
    end
    bus.mem_ack = 1'b0;
    check("rreq_result", byte_accessL, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
